// File: rtl/issue_queue_pair.sv
// Instruction queue between fetch and decode: circular buffer with a show-ahead
// head pair, hazard-based dual-issue pairing, flush (redirect) and halt handling.
module issue_queue_pair #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 16,
    parameter int ISSUE_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [1:0]             fetch_vld,
    input  logic [2*INSTR_W-1:0]   fetch_instr,
    input  logic [2*PC_W-1:0]      fetch_pc,
    output logic                   fetch_rdy,
    output logic [1:0]             iss_vld,
    output logic [2*INSTR_W-1:0]   iss_instr,
    output logic [2*PC_W-1:0]      iss_pc,
    input  logic                   iss_stall,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Opcode map of field [31:27]; codes not listed are plain register writers.
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDZ = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_NOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_SUBI = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_UMUL = 5'd11;
    localparam logic [4:0] OP_ADDF = 5'd12;
    localparam logic [4:0] OP_SUBF = 5'd13;
    localparam logic [4:0] OP_MULF = 5'd14;
    localparam logic [4:0] OP_ITF  = 5'd15;
    localparam logic [4:0] OP_FTI  = 5'd16;
    localparam logic [4:0] OP_LW   = 5'd17;
    localparam logic [4:0] OP_SW   = 5'd18;
    localparam logic [4:0] OP_LWI  = 5'd19;
    localparam logic [4:0] OP_PUSH = 5'd20;
    localparam logic [4:0] OP_POP  = 5'd21;
    localparam logic [4:0] OP_BR   = 5'd22;
    localparam logic [4:0] OP_JAL  = 5'd23;
    localparam logic [4:0] OP_JR   = 5'd24;
    localparam logic [4:0] OP_HLT  = 5'd25;

    function automatic logic is_writer(input logic [4:0] op);
        return !(op inside {OP_SW, OP_BR, OP_JR, OP_PUSH, OP_HLT});
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return op inside {OP_LW, OP_SW, OP_LWI, OP_PUSH, OP_POP};
    endfunction

    function automatic logic is_ext(input logic [4:0] op);
        return op inside {OP_MUL, OP_UMUL, OP_ADDF, OP_SUBF, OP_MULF, OP_ITF, OP_FTI};
    endfunction

    function automatic logic sets_flags(input logic [4:0] op);
        return (op inside {OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR, OP_SLL, OP_SRL,
                           OP_SRA, OP_ADDI, OP_SUBI}) || is_ext(op);
    endfunction

    // JAL links into r31 regardless of its dst field.
    function automatic logic [4:0] dst_of(input logic [4:0] op, input logic [4:0] dst_field);
        return (op == OP_JAL) ? 5'd31 : dst_field;
    endfunction

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW-1:0] rd_ptr_p1, wr_ptr_p1;
    logic [CW-1:0] count;
    logic          halted_q;

    logic [INSTR_W-1:0] head0, head1;
    logic [4:0]         op0, op1, dst0, dst1;
    logic               split, vld0, vld1;
    logic               do_write, pop_hlt;
    logic [1:0]         n_wr, n_pop;

    assign rd_ptr_p1 = rd_ptr + AW'(1);
    assign wr_ptr_p1 = wr_ptr + AW'(1);

    assign head0 = instr_mem[rd_ptr];
    assign head1 = instr_mem[rd_ptr_p1];
    assign op0   = head0[31:27];
    assign op1   = head1[31:27];
    assign dst0  = dst_of(op0, head0[20:16]);
    assign dst1  = dst_of(op1, head1[20:16]);

    always_comb begin
        split = 1'b0;
        if (op0 inside {OP_BR, OP_JAL, OP_JR, OP_HLT} || op1 == OP_HLT)
            split = 1'b1;
        // RAW is deliberately conservative: every slot1 register field is compared.
        if (is_writer(op0) && dst0 != 5'd0 &&
            (dst0 == head1[4:0] || dst0 == head1[12:8] || dst0 == head1[20:16]))
            split = 1'b1;
        if (is_writer(op0) && is_writer(op1) && dst0 != 5'd0 && dst0 == dst1)
            split = 1'b1;
        if (is_mem(op0) && is_mem(op1))
            split = 1'b1;
        if (is_ext(op0) && is_ext(op1))
            split = 1'b1;
        if (sets_flags(op0) && (op1 == OP_ADDZ || op1 == OP_BR))
            split = 1'b1;
    end

    // Handshake: fetch entries are taken on a clock edge when fetch_vld[0] and
    // fetch_rdy are high and flush is low; fetch_rdy reflects only the registered
    // count. Issue slots pop on an edge when iss_vld is high and iss_stall is low.
    assign fetch_rdy = (count <= CW'(DEPTH - 2));
    assign vld0      = (count != '0) && !halted_q && !flush;
    assign vld1      = (ISSUE_W == 2) && vld0 && (count >= CW'(2)) && !split;
    assign iss_vld   = {vld1, vld0};
    assign iss_instr = {head1, head0};
    assign iss_pc    = {pc_mem[rd_ptr_p1], pc_mem[rd_ptr]};
    assign occupancy = count;
    assign halted    = halted_q;

    assign do_write = fetch_vld[0] && fetch_rdy && !flush;
    assign n_wr     = do_write ? (fetch_vld[1] ? 2'd2 : 2'd1) : 2'd0;
    assign n_pop    = iss_stall ? 2'd0 : ({1'b0, vld0} + {1'b0, vld1});
    assign pop_hlt  = !iss_stall && vld0 && (op0 == OP_HLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + AW'(n_pop);
            wr_ptr <= wr_ptr + AW'(n_wr);
            count  <= count + CW'(n_wr) - CW'(n_pop);
            if (pop_hlt)
                halted_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: an entry is only observed once the count covers it.
    always_ff @(posedge clk) begin
        if (do_write) begin
            instr_mem[wr_ptr] <= fetch_instr[INSTR_W-1:0];
            pc_mem[wr_ptr]    <= fetch_pc[PC_W-1:0];
            if (fetch_vld[1]) begin
                instr_mem[wr_ptr_p1] <= fetch_instr[2*INSTR_W-1:INSTR_W];
                pc_mem[wr_ptr_p1]    <= fetch_pc[2*PC_W-1:PC_W];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_pair.sv
// Directed bench for issue_queue_pair: pairing table plus fill/wrap, halt,
// flush, async reset and scalar-mode sequences.
module tb_issue_queue_pair;
    localparam logic [4:0] OP_ADD = 5'd0, OP_ADDZ = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3,
                           OP_NOR = 5'd4, OP_ADDI = 5'd8, OP_MUL = 5'd10, OP_ADDF = 5'd12,
                           OP_ITF = 5'd15, OP_FTI = 5'd16, OP_LW = 5'd17, OP_SW = 5'd18,
                           OP_PUSH = 5'd20, OP_POP = 5'd21, OP_BR = 5'd22, OP_JAL = 5'd23,
                           OP_JR = 5'd24, OP_HLT = 5'd25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, iss_stall, fetch_rdy, halted;
    logic [1:0]  fetch_vld, iss_vld;
    logic [63:0] fetch_instr, iss_instr;
    logic [31:0] fetch_pc, iss_pc;
    logic [3:0]  occupancy;

    logic        s_flush, s_stall, s_rdy, s_halted;
    logic [1:0]  s_fvld, s_ivld;
    logic [63:0] s_finstr, s_iinstr;
    logic [31:0] s_fpc, s_ipc;
    logic [3:0]  s_occ;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    issue_queue_pair #(.DEPTH(8), .INSTR_W(32), .PC_W(16), .ISSUE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_vld(fetch_vld),
        .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_rdy(fetch_rdy),
        .iss_vld(iss_vld), .iss_instr(iss_instr), .iss_pc(iss_pc),
        .iss_stall(iss_stall), .occupancy(occupancy), .halted(halted)
    );

    issue_queue_pair #(.DEPTH(8), .INSTR_W(32), .PC_W(16), .ISSUE_W(1)) dut_scalar (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .fetch_vld(s_fvld),
        .fetch_instr(s_finstr), .fetch_pc(s_fpc), .fetch_rdy(s_rdy),
        .iss_vld(s_ivld), .iss_instr(s_iinstr), .iss_pc(s_ipc),
        .iss_stall(s_stall), .occupancy(s_occ), .halted(s_halted)
    );

    typedef struct {
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  exp_vld;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [31:0] mk(input logic [4:0] op, input int d, input int s1, input int s0);
        return {op, 6'd0, 5'(d), 3'd0, 5'(s1), 3'd0, 5'(s0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        exp_q.delete();
    endtask

    task automatic push(input logic [1:0] vld, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [15:0] p0, input logic [15:0] p1);
        fetch_vld   = vld;
        fetch_instr = {i1, i0};
        fetch_pc    = {p1, p0};
        exp_q.push_back(p0);
        if (vld[1]) exp_q.push_back(p1);
        tick();
        fetch_vld = 2'b00;
        #1;
    endtask

    // One unstalled cycle; the expected slot PCs come from the scoreboard queue.
    task automatic issue_cycle(input string name, input logic [1:0] exp_vld);
        logic [15:0] e;
        check({name, "_vld"}, iss_vld, exp_vld);
        for (int s = 0; s < 2; s++) begin
            if (exp_vld[s]) begin
                if (exp_q.size() == 0) begin
                    check({name, "_sb_empty"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_pc%0d", name, s), iss_pc[16*s +: 16], e);
                end
            end
        end
        iss_stall = 1'b0;
        tick();
        iss_stall = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; iss_stall = 1'b1;
        fetch_vld = 2'b00; fetch_instr = '0; fetch_pc = '0;
        s_flush = 1'b0; s_stall = 1'b1; s_fvld = 2'b00; s_finstr = '0; s_fpc = '0;
        #1;
        check("rst_occ", occupancy, 0);
        check("rst_vld", iss_vld, 0);
        check("rst_rdy", fetch_rdy, 1);
        check("rst_halted", halted, 0);
        tick();
        rst_n = 1'b1;
        tick();

        vecs[0]  = '{mk(OP_ADD, 1, 2, 3),   mk(OP_ADD, 4, 5, 6),  2'b11};
        vecs[1]  = '{mk(OP_ADD, 1, 2, 3),   mk(OP_SUB, 7, 1, 2),  2'b01};
        vecs[2]  = '{mk(OP_LW, 1, 2, 0),    mk(OP_SW, 3, 4, 5),   2'b01};
        vecs[3]  = '{mk(OP_MUL, 1, 2, 3),   mk(OP_ADDF, 4, 5, 6), 2'b01};
        vecs[4]  = '{mk(OP_SUB, 1, 2, 3),   mk(OP_BR, 0, 0, 0),   2'b01};
        vecs[5]  = '{mk(OP_BR, 0, 0, 0),    mk(OP_ADD, 4, 5, 6),  2'b01};
        vecs[6]  = '{mk(OP_ADD, 1, 2, 3),   mk(OP_HLT, 0, 0, 0),  2'b01};
        vecs[7]  = '{mk(OP_ADD, 0, 2, 3),   mk(OP_ADD, 5, 0, 0),  2'b11};
        vecs[8]  = '{mk(OP_ADD, 31, 1, 2),  mk(OP_JAL, 0, 0, 0),  2'b01};
        vecs[9]  = '{mk(OP_ADD, 30, 1, 2),  mk(OP_JAL, 0, 0, 0),  2'b11};
        vecs[10] = '{mk(OP_ADD, 1, 2, 3),   mk(OP_ADDZ, 4, 5, 6), 2'b01};
        vecs[11] = '{mk(OP_LW, 1, 2, 3),    mk(OP_ADDZ, 4, 5, 6), 2'b11};
        vecs[12] = '{mk(OP_SW, 1, 2, 3),    mk(OP_BR, 0, 0, 0),   2'b11};
        vecs[13] = '{mk(OP_ADD, 9, 1, 2),   mk(OP_AND, 4, 5, 9),  2'b01};
        vecs[14] = '{mk(OP_SW, 9, 1, 2),    mk(OP_AND, 4, 5, 9),  2'b11};
        vecs[15] = '{mk(OP_POP, 3, 0, 0),   mk(OP_PUSH, 0, 1, 2), 2'b01};
        vecs[16] = '{mk(OP_JR, 0, 1, 0),    mk(OP_ADD, 4, 5, 6),  2'b01};
        vecs[17] = '{mk(OP_ITF, 1, 2, 0),   mk(OP_FTI, 4, 5, 0),  2'b01};
        vecs[18] = '{mk(OP_ADDI, 5, 1, 0),  mk(OP_SW, 0, 2, 3),   2'b11};
        vecs[19] = '{mk(OP_ADDI, 5, 1, 0),  mk(OP_BR, 0, 0, 0),   2'b01};
        vecs[20] = '{mk(OP_NOR, 8, 1, 2),   mk(OP_ADD, 4, 8, 3),  2'b01};

        for (int i = 0; i < 21; i++) begin
            do_flush();
            push(2'b11, vecs[i].i0, vecs[i].i1, 16'h0010, 16'h0011);
            check($sformatf("v%0d_occ2", i), occupancy, 2);
            check($sformatf("v%0d_vld", i), iss_vld, vecs[i].exp_vld);
            check($sformatf("v%0d_slot0", i), iss_instr[31:0], vecs[i].i0);
            if (vecs[i].exp_vld[1])
                check($sformatf("v%0d_slot1", i), iss_instr[63:32], vecs[i].i1);
            iss_stall = 1'b0;
            tick();
            iss_stall = 1'b1;
            #1;
            if (!vecs[i].exp_vld[1]) begin
                check($sformatf("v%0d_vld2", i), iss_vld, 2'b01);
                check($sformatf("v%0d_slot0_2", i), iss_instr[31:0], vecs[i].i1);
                check($sformatf("v%0d_occ1", i), occupancy, 1);
                iss_stall = 1'b0;
                tick();
                iss_stall = 1'b1;
                #1;
            end
            check($sformatf("v%0d_occ0", i), occupancy, 0);
            check($sformatf("v%0d_empty", i), iss_vld, 0);
        end

        // Fill to 7 under stall, refused offer, drain, refill to 8 across the wrap.
        do_flush();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("fill_rdy%0d", k), fetch_rdy, 1);
            push(2'b11, mk(OP_ADD, 2*k+1, 0, 0), mk(OP_ADD, 2*k+2, 0, 0),
                 16'(2*k), 16'(2*k+1));
        end
        check("fill_rdy6", fetch_rdy, 1);
        push(2'b01, mk(OP_ADD, 7, 0, 0), '0, 16'd6, 16'd0);
        check("fill_occ7", occupancy, 7);
        check("fill_rdy7", fetch_rdy, 0);
        fetch_vld = 2'b11; fetch_instr = {mk(OP_ADD, 20, 0, 0), mk(OP_ADD, 21, 0, 0)};
        fetch_pc = {16'hdead, 16'hbeef};
        tick();
        fetch_vld = 2'b00;
        #1;
        check("blocked_occ7", occupancy, 7);
        iss_stall = 1'b0;
        #1;
        check("rdy_no_credit", fetch_rdy, 0);
        iss_stall = 1'b1;
        issue_cycle("drain0", 2'b11);
        issue_cycle("drain1", 2'b11);
        issue_cycle("drain2", 2'b11);
        issue_cycle("drain3", 2'b01);
        check("drain_occ0", occupancy, 0);
        for (int k = 0; k < 4; k++)
            push(2'b11, mk(OP_ADD, 2*k+8, 0, 0), mk(OP_ADD, 2*k+9, 0, 0),
                 16'(2*k+7), 16'(2*k+8));
        check("wrap_occ8", occupancy, 8);
        check("wrap_rdy8", fetch_rdy, 0);
        for (int k = 0; k < 4; k++)
            issue_cycle($sformatf("wrap%0d", k), 2'b11);
        check("wrap_occ0", occupancy, 0);
        check("wrap_sb_left", exp_q.size(), 0);

        // HLT issues alone, then the queue goes quiet until flush.
        do_flush();
        push(2'b11, mk(OP_HLT, 0, 0, 0), mk(OP_ADD, 4, 5, 6), 16'h0040, 16'h0041);
        check("hlt_slot0", iss_instr[31:0], mk(OP_HLT, 0, 0, 0));
        issue_cycle("hlt", 2'b01);
        check("hlt_halted", halted, 1);
        check("hlt_vld", iss_vld, 0);
        check("hlt_occ1", occupancy, 1);
        iss_stall = 1'b0;
        tick(); tick();
        iss_stall = 1'b1;
        #1;
        check("hlt_still_vld", iss_vld, 0);
        check("hlt_still_occ", occupancy, 1);
        push(2'b11, mk(OP_ADD, 1, 0, 0), mk(OP_ADD, 2, 0, 0), 16'h0042, 16'h0043);
        check("hlt_fetch_occ3", occupancy, 3);
        do_flush();
        check("hlt_flush_occ", occupancy, 0);
        check("hlt_flush_halted", halted, 0);

        // Flush beats a concurrent fetch and pop.
        push(2'b11, mk(OP_ADD, 1, 2, 3), mk(OP_ADD, 4, 5, 6), 16'h0050, 16'h0051);
        flush = 1'b1; iss_stall = 1'b0; fetch_vld = 2'b11;
        fetch_instr = {mk(OP_ADD, 7, 0, 0), mk(OP_ADD, 8, 0, 0)};
        #1;
        check("flush_cycle_vld", iss_vld, 0);
        tick();
        flush = 1'b0; iss_stall = 1'b1; fetch_vld = 2'b00;
        #1;
        exp_q.delete();
        check("flush_occ0", occupancy, 0);
        check("flush_vld0", iss_vld, 0);

        // Asynchronous reset while halted with an entry held.
        push(2'b11, mk(OP_HLT, 0, 0, 0), mk(OP_ADD, 4, 5, 6), 16'h0060, 16'h0061);
        issue_cycle("pre_rst", 2'b01);
        check("pre_rst_halted", halted, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_occ", occupancy, 0);
        check("arst_halted", halted, 0);
        check("arst_rdy", fetch_rdy, 1);
        check("arst_vld", iss_vld, 0);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        tick();

        // Scalar instance: four independent ADDs issue one per cycle.
        s_fvld = 2'b11;
        s_finstr = {mk(OP_ADD, 2, 0, 0), mk(OP_ADD, 1, 0, 0)}; s_fpc = {16'd101, 16'd100};
        tick();
        s_finstr = {mk(OP_ADD, 4, 0, 0), mk(OP_ADD, 3, 0, 0)}; s_fpc = {16'd103, 16'd102};
        tick();
        s_fvld = 2'b00;
        s_stall = 1'b0;
        #1;
        check("scalar_occ4", s_occ, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("scalar%0d_vld", k), s_ivld, 2'b01);
            check($sformatf("scalar%0d_pc", k), s_ipc[15:0], 16'(100 + k));
            tick();
        end
        check("scalar_empty_vld", s_ivld, 0);
        check("scalar_occ0", s_occ, 0);
        s_stall = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
